// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALU codes, opcode/funct values and the
// decoded ID/EX bundle layout used by the decoder and the execute-stage ALU.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic [3:0]        alu_ctrl;
    logic [WORD_W-1:0] imm;
    logic              use_imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              illegal;
  } id_bundle_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    id_bundle_t        bun;
  } id_entry_t;

  function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
    return {{(WORD_W-16){v[15]}}, v};
  endfunction

  function automatic logic [WORD_W-1:0] zext16(input logic [15:0] v);
    return {{(WORD_W-16){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_comb.sv
// Pure combinational MIPS instruction -> id_bundle_t decode.
// Unsupported encodings come out as ADD with illegal set and every enable low.
module alu_ctrl_decode_comb
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] instr_i,
  output id_bundle_t        bundle_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       r_ok;
  logic       i_ok;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];

  always_comb begin
    bundle_o          = '0;
    bundle_o.alu_ctrl = ALU_ADD;
    bundle_o.rs       = instr_i[25:21];
    bundle_o.rt       = instr_i[20:16];
    bundle_o.illegal  = 1'b1;
    r_ok              = 1'b0;
    i_ok              = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        // The all-zero word is sll $0 (nop): legal, but writes nothing.
        if (instr_i == '0) begin
          bundle_o.illegal = 1'b0;
        end else begin
          case (funct)
            FN_ADD, FN_ADDU: begin r_ok = 1'b1; bundle_o.alu_ctrl = ALU_ADD; end
            FN_SUB, FN_SUBU: begin r_ok = 1'b1; bundle_o.alu_ctrl = ALU_SUB; end
            FN_AND:          begin r_ok = 1'b1; bundle_o.alu_ctrl = ALU_AND; end
            FN_OR:           begin r_ok = 1'b1; bundle_o.alu_ctrl = ALU_OR;  end
            FN_SLT:          begin r_ok = 1'b1; bundle_o.alu_ctrl = ALU_SLT; end
            default:         ;
          endcase
        end
      end
      OP_ADDI, OP_ADDIU: begin
        i_ok = 1'b1; bundle_o.alu_ctrl = ALU_ADD; bundle_o.imm = sext16(instr_i[15:0]);
        bundle_o.reg_write = 1'b1;
      end
      OP_SLTI: begin
        i_ok = 1'b1; bundle_o.alu_ctrl = ALU_SLT; bundle_o.imm = sext16(instr_i[15:0]);
        bundle_o.reg_write = 1'b1;
      end
      OP_ANDI: begin
        i_ok = 1'b1; bundle_o.alu_ctrl = ALU_AND; bundle_o.imm = zext16(instr_i[15:0]);
        bundle_o.reg_write = 1'b1;
      end
      OP_ORI: begin
        i_ok = 1'b1; bundle_o.alu_ctrl = ALU_OR; bundle_o.imm = zext16(instr_i[15:0]);
        bundle_o.reg_write = 1'b1;
      end
      OP_LW: begin
        i_ok = 1'b1; bundle_o.alu_ctrl = ALU_ADD; bundle_o.imm = sext16(instr_i[15:0]);
        bundle_o.mem_read = 1'b1; bundle_o.reg_write = 1'b1;
      end
      OP_SW: begin
        i_ok = 1'b1; bundle_o.alu_ctrl = ALU_ADD; bundle_o.imm = sext16(instr_i[15:0]);
        bundle_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        // Comparison runs on two registers; imm carries the branch offset only.
        bundle_o.illegal  = 1'b0;
        bundle_o.alu_ctrl = ALU_SUB;
        bundle_o.imm      = sext16(instr_i[15:0]);
        bundle_o.rd       = instr_i[20:16];
        bundle_o.branch   = 1'b1;
      end
      default: ;
    endcase

    if (r_ok) begin
      bundle_o.illegal   = 1'b0;
      bundle_o.reg_write = 1'b1;
      bundle_o.rd        = instr_i[15:11];
    end
    if (i_ok) begin
      bundle_o.illegal = 1'b0;
      bundle_o.use_imm = 1'b1;
      bundle_o.rd      = instr_i[20:16];
    end
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// ID stage: decodes instructions into a registered ID/EX bundle, 1-cycle latency.
// One-entry skid behind the output register; in_ready depends on registered state only.
module alu_ctrl_decoder
  import mips_pkg::*;
#(
  parameter int XLEN = WORD_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_illegal
);

  id_bundle_t dec_bun;
  id_entry_t  new_entry;
  id_entry_t  out_q, out_d;
  id_entry_t  skid_q, skid_d;
  logic       out_v_q, out_v_d;
  logic       skid_v_q, skid_v_d;
  logic       in_fire;
  logic       out_fire;

  alu_ctrl_decode_comb u_dec (
    .instr_i  (in_instr),
    .bundle_o (dec_bun)
  );

  assign new_entry = '{pc: in_pc, bun: dec_bun};
  assign in_ready  = !skid_v_q && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_v_q && out_ready;

  always_comb begin
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    out_d    = out_q;
    skid_d   = skid_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_fire && skid_v_q) begin
      // in_ready was low, so no input can arrive alongside the skid refill.
      out_d    = skid_q;
      skid_v_d = 1'b0;
    end else if (in_fire && (!out_v_q || out_fire)) begin
      out_d   = new_entry;
      out_v_d = 1'b1;
    end else if (in_fire) begin
      skid_d   = new_entry;
      skid_v_d = 1'b1;
    end else if (out_fire) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
    end
  end

  assign out_valid     = out_v_q;
  assign out_pc        = out_q.pc;
  assign out_alu_ctrl  = out_q.bun.alu_ctrl;
  assign out_imm       = out_q.bun.imm;
  assign out_use_imm   = out_q.bun.use_imm;
  assign out_rs        = out_q.bun.rs;
  assign out_rt        = out_q.bun.rt;
  assign out_rd        = out_q.bun.rd;
  assign out_reg_write = out_q.bun.reg_write;
  assign out_mem_read  = out_q.bun.mem_read;
  assign out_mem_write = out_q.bun.mem_write;
  assign out_branch    = out_q.bun.branch;
  assign out_illegal   = out_q.bun.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: directed scenarios plus an in-order scoreboard
// fed on every input transfer and drained on every output transfer.
module tb_alu_ctrl_decoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [3:0]  out_alu_ctrl;
  logic        out_use_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [88:0] got;

  int checks = 0;
  int errors = 0;
  logic [88:0] sb[$];

  always #5 clk = ~clk;

  alu_ctrl_decoder #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_ctrl(out_alu_ctrl), .out_imm(out_imm), .out_use_imm(out_use_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_illegal(out_illegal)
  );

  assign got = {out_pc, out_alu_ctrl, out_imm, out_use_imm, out_rs, out_rt, out_rd,
                out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal};

  // Reference decode, written straight from the instruction table.
  function automatic logic [88:0] exp_of(input logic [31:0] w, input logic [31:0] pc);
    logic [3:0]  a;
    logic [31:0] im, se, ze;
    logic [4:0]  d;
    logic        ui, rw, mr, mw, br, il;
    a = 4'd0; im = 32'd0; d = 5'd0; ui = 0; rw = 0; mr = 0; mw = 0; br = 0; il = 0;
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0000, w[15:0]};
    case (w[31:26])
      6'h00: if (w != 32'd0) begin
        case (w[5:0])
          6'h20, 6'h21: a = 4'b0000;
          6'h22, 6'h23: a = 4'b0001;
          6'h24:        a = 4'b0010;
          6'h25:        a = 4'b0011;
          6'h2A:        a = 4'b0100;
          default:      il = 1;
        endcase
        if (!il) begin rw = 1; d = w[15:11]; end
      end
      6'h08, 6'h09: begin a = 4'b0000; im = se; ui = 1; rw = 1; d = w[20:16]; end
      6'h0A:        begin a = 4'b0100; im = se; ui = 1; rw = 1; d = w[20:16]; end
      6'h0C:        begin a = 4'b0010; im = ze; ui = 1; rw = 1; d = w[20:16]; end
      6'h0D:        begin a = 4'b0011; im = ze; ui = 1; rw = 1; d = w[20:16]; end
      6'h23:        begin im = se; ui = 1; mr = 1; rw = 1; d = w[20:16]; end
      6'h2B:        begin im = se; ui = 1; mw = 1; d = w[20:16]; end
      6'h04:        begin a = 4'b0001; im = se; br = 1; d = w[20:16]; end
      default:      il = 1;
    endcase
    return {pc, a, im, ui, w[25:21], w[20:16], d, rw, mr, mw, br, il};
  endfunction

  // Scoreboard: push on input transfer, pop/compare on output transfer.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got bundle %h, required no output", got);
        end else begin
          logic [88:0] e;
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sb_bundle: got %h, required %h", got, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_of(in_instr, in_pc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b bundle=%h, required 0/0/0",
               out_valid, in_ready, got);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_decode_back_to_back();
    logic [31:0] prog [16];
    prog = '{32'h012A4020, 32'h3528FFFF, 32'h2128FFFF, 32'h8D280004,
             32'h11090003, 32'hFC000000, 32'h00000000, 32'h012A4022,
             32'h012A4024, 32'h012A4025, 32'h012A402A, 32'h2928FFFF,
             32'h3128FFFF, 32'hAD280004, 32'h012A4026, 32'h25280010};
    out_ready = 1;
    in_valid  = 1;
    for (int i = 0; i < 16; i++) begin
      in_instr = prog[i];
      in_pc    = 32'h0040_0000 + 32'(i * 4);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL latency_%0d: out_valid=%b out_pc=%h, required 1/%h",
                 i, out_valid, out_pc, 32'h0040_0000 + 32'(i * 4));
      end
      if (i == 0) begin
        checks++;
        if (out_alu_ctrl !== 4'b0000 || out_rs !== 5'd9 || out_rt !== 5'd10 || out_rd !== 5'd8 ||
            out_reg_write !== 1'b1 || out_use_imm !== 1'b0) begin
          errors++;
          $display("FAIL add_fields: alu=%b rs=%0d rt=%0d rd=%0d rw=%b ui=%b, required 0000/9/10/8/1/0",
                   out_alu_ctrl, out_rs, out_rt, out_rd, out_reg_write, out_use_imm);
        end
      end
      if (i == 1) begin
        checks++;
        if (out_alu_ctrl !== 4'b0011 || out_imm !== 32'h0000FFFF) begin
          errors++;
          $display("FAIL ori_fields: alu=%b imm=%h, required 0011/0000ffff", out_alu_ctrl, out_imm);
        end
      end
      if (i == 2) begin
        checks++;
        if (out_alu_ctrl !== 4'b0000 || out_imm !== 32'hFFFFFFFF) begin
          errors++;
          $display("FAIL addi_fields: alu=%b imm=%h, required 0000/ffffffff", out_alu_ctrl, out_imm);
        end
      end
      if (i == 3) begin
        checks++;
        if (out_alu_ctrl !== 4'b0000 || out_mem_read !== 1'b1 || out_rd !== 5'd8) begin
          errors++;
          $display("FAIL lw_fields: alu=%b mr=%b rd=%0d, required 0000/1/8",
                   out_alu_ctrl, out_mem_read, out_rd);
        end
      end
      if (i == 4) begin
        checks++;
        if (out_alu_ctrl !== 4'b0001 || out_branch !== 1'b1 || out_reg_write !== 1'b0 ||
            out_imm !== 32'd3) begin
          errors++;
          $display("FAIL beq_fields: alu=%b br=%b rw=%b imm=%h, required 0001/1/0/3",
                   out_alu_ctrl, out_branch, out_reg_write, out_imm);
        end
      end
      if (i == 5) begin
        checks++;
        if (out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_mem_read !== 1'b0 ||
            out_mem_write !== 1'b0 || out_branch !== 1'b0 || out_alu_ctrl !== 4'b0000) begin
          errors++;
          $display("FAIL illegal_fields: ill=%b rw=%b mr=%b mw=%b br=%b alu=%b, required 1/0/0/0/0/0000",
                   out_illegal, out_reg_write, out_mem_read, out_mem_write, out_branch, out_alu_ctrl);
        end
      end
    end
    in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] s [4];
    logic [88:0] snap;
    logic        acc;
    int          k;
    s = '{32'h012A4022, 32'h3528AAAA, 32'hAD280010, 32'h012A402A};
    snap = '0;
    k = 0;
    in_valid = 1; in_instr = s[0]; in_pc = 32'h0000_1000;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c >= 3);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k == 2) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid_full_ready: in_ready=%b, required 0", in_ready);
          end
          snap = got;
        end
        if (k < 4) begin
          in_instr = s[k];
          in_pc    = 32'h0000_1000 + 32'(k * 4);
        end else begin
          in_valid = 0;
        end
      end
      if (c == 2) begin
        checks++;
        if (out_valid !== 1'b1 || got !== snap) begin
          errors++;
          $display("FAIL stall_stable: out_valid=%b bundle=%h, required 1/%h", out_valid, got, snap);
        end
      end
      if (k == 4 && !out_valid) break;
    end
    checks++;
    if (k != 4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_done: accepted=%0d out_valid=%b, required 4/0", k, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_instr = 32'h012A4020; in_pc = 32'h0000_2000;
    @(posedge clk); #1;
    in_instr = 32'h012A4024; in_pc = 32'h0000_2004;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    in_instr = 32'h012A4025; in_pc = 32'h0000_2008; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: out_valid=%b, required 0", out_valid);
    end
    in_valid = 1; in_instr = 32'h2128_0007; in_pc = 32'h0000_200C;
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_200C) begin
      errors++;
      $display("FAIL flush_resume: out_valid=%b out_pc=%h, required 1/0000200c", out_valid, out_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 0;
    in_valid = 1; in_instr = 32'h8D280004; in_pc = 32'h0000_3000;
    @(posedge clk); #1;
    in_instr = 32'h3528FFFF; in_pc = 32'h0000_3004;
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b bundle=%h, required 0/0/0",
               out_valid, in_ready, got);
    end
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    in_valid = 1; in_instr = 32'h012A4020; in_pc = 32'h0000_3008;
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_3008 || out_rd !== 5'd8) begin
      errors++;
      $display("FAIL midreset_first: out_valid=%b out_pc=%h rd=%0d, required 1/00003008/8",
               out_valid, out_pc, out_rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_decode_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_stream();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d bundles never emerged, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
